// File: rtl/rr_arbiter4_if.sv
// ---------------------------------------------------------------------------
// rr_arbiter4_if
// Bus between the four requesters and the round-robin arbiter.
//
// Handshake: a requester holds req[n] high for as long as it wants the
// shared resource. The arbiter answers with a registered one-hot grant,
// gnt_idx and gnt_valid. The owner keeps req[n] high while it uses the
// resource and ends its tenure by pulsing done or by dropping req[n]. Other
// requesters keep waiting; there is no preemption.
//
// Signals:
//   req       requester -> arbiter  4  request vector, bit n = requester n
//   done      requester -> arbiter  1  current owner finished
//   grant     arbiter -> requester  4  one-hot grant, zero when no owner
//   gnt_idx   arbiter -> requester  2  encoded grant index (held when idle)
//   gnt_valid arbiter -> requester  1  a grant is active
//   timeout   arbiter -> requester  1  one-cycle pulse on forced release
//
// Modports:
//   master  requester side (drives req/done)
//   slave   arbiter side   (drives grant/gnt_idx/gnt_valid/timeout)
// ---------------------------------------------------------------------------
interface rr_arbiter4_if;
  logic [3:0] req;
  logic       done;
  logic [3:0] grant;
  logic [1:0] gnt_idx;
  logic       gnt_valid;
  logic       timeout;

  modport master (
    output req,
    output done,
    input  grant,
    input  gnt_idx,
    input  gnt_valid,
    input  timeout
  );

  modport slave (
    input  req,
    input  done,
    output grant,
    output gnt_idx,
    output gnt_valid,
    output timeout
  );
endinterface

// File: rtl/rr_arbiter4.sv
// ---------------------------------------------------------------------------
// rr_arbiter4
// Four-requester round-robin arbiter for one shared resource.
//
// A requester is selected by searching req from ptr+1 upward (mod 4), where
// ptr is the index of the most recent owner. The winner holds the grant
// until it pulses done or drops its request. Every release passes through a
// single RELEASE cycle with the grant cleared, so the datapath mux always
// sees at least one idle cycle between owners.
//
// Optional feature (macro RR_ARBITER4_TIMEOUT_EN):
//   When defined, an owner that keeps the grant for MAX_HOLD cycles is
//   released forcibly and timeout pulses for one cycle. When undefined the
//   grant is held indefinitely and timeout is tied low.
//
// Parameters:
//   MAX_HOLD  grant cycles before forced release (1..255)
//   CNT_W     hold counter width, 2**CNT_W > MAX_HOLD
//
// Ports:
//   clk             clock, all state changes on the rising edge
//   rst             synchronous active-high reset
//   bus             rr_arbiter4_if.slave (req, done in; grant, gnt_idx,
//                   gnt_valid, timeout out; all outputs registered)
//   dbg_state       current FSM state (IDLE=0, GRANT=1, RELEASE=2)
//   dbg_hold_cnt    cycles the current owner has held the grant
//   dbg_hold_limit  hold counter has reached MAX_HOLD-1
// ---------------------------------------------------------------------------
module rr_arbiter4 #(
  parameter int MAX_HOLD = 15,
  parameter int CNT_W    = 8
) (
  input  logic             clk,
  input  logic             rst,
  rr_arbiter4_if.slave     bus,
  output logic [1:0]       dbg_state,
  output logic [CNT_W-1:0] dbg_hold_cnt,
  output logic             dbg_hold_limit
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_GRANT   = 2'd1;
  localparam logic [1:0] S_RELEASE = 2'd2;

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

  // Registered state
  logic [1:0]       state_q;
  logic [1:0]       ptr_q;
  logic [3:0]       grant_q;
  logic [1:0]       idx_q;
  logic             valid_q;
  logic             timeout_q;
  logic [CNT_W-1:0] hold_q;

  // Next-state values
  logic [1:0]       state_d;
  logic [1:0]       ptr_d;
  logic [3:0]       grant_d;
  logic [1:0]       idx_d;
  logic             valid_d;
  logic             timeout_d;
  logic [CNT_W-1:0] hold_d;

  // Selection result
  logic             sel_found;
  logic [1:0]       sel_idx;

  // Release qualifiers
  logic             release_cond;
  logic             force_release;

  // -------------------------------------------------------------------------
  // Round-robin selection: first requester at ptr+1, ptr+2, ptr+3, ptr.
  // The 2-bit add wraps naturally, so the fourth candidate is ptr itself,
  // which lets a lone requester win again right after its own release.
  // -------------------------------------------------------------------------
  always_comb begin
    logic [1:0] cand;
    sel_found = 1'b0;
    sel_idx   = ptr_q;
    cand      = ptr_q;
    for (int i = 1; i <= 4; i++) begin
      cand = ptr_q + i[1:0];
      if (!sel_found && bus.req[cand]) begin
        sel_found = 1'b1;
        sel_idx   = cand;
      end
    end
  end

  // The owner is done when it says so or stops asking. Both at once is a
  // single release since it is one condition evaluated once per cycle.
  assign release_cond = bus.done || !bus.req[idx_q];

`ifdef RR_ARBITER4_TIMEOUT_EN
  // hold_q counts from 0 in the first GRANT cycle, so reaching MAX_HOLD-1
  // means this is the MAX_HOLD-th cycle of ownership.
  assign force_release = (state_q == S_GRANT) && !release_cond &&
                         (hold_q == HOLD_LAST);
`else
  assign force_release = 1'b0;
`endif

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    grant_d   = grant_q;
    idx_d     = idx_q;
    valid_d   = valid_q;
    timeout_d = 1'b0;
    hold_d    = hold_q;

    case (state_q)
      S_IDLE: begin
        // done is meaningless without an owner and is ignored here.
        if (sel_found) begin
          state_d = S_GRANT;
          grant_d = 4'b0001 << sel_idx;
          idx_d   = sel_idx;
          valid_d = 1'b1;
          hold_d  = '0;
        end
      end

      S_GRANT: begin
        if (hold_q != '1) begin
          hold_d = hold_q + CNT_W'(1);
        end
        if (release_cond || force_release) begin
          // gnt_idx keeps the last owner so the datapath steering is stable
          // through the idle slot; ptr moves so that owner goes to the back.
          state_d   = S_RELEASE;
          grant_d   = 4'b0000;
          valid_d   = 1'b0;
          ptr_d     = idx_q;
          timeout_d = force_release;
        end
      end

      S_RELEASE: begin
        // ptr already names the owner just released, so the search starts
        // with its right-hand neighbour.
        if (sel_found) begin
          state_d = S_GRANT;
          grant_d = 4'b0001 << sel_idx;
          idx_d   = sel_idx;
          valid_d = 1'b1;
          hold_d  = '0;
        end else begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
        grant_d = 4'b0000;
        valid_d = 1'b0;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // State registers; reset wins over any grant in progress.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      ptr_q     <= 2'd3;  // requester 0 searched first after reset
      grant_q   <= 4'b0000;
      idx_q     <= 2'd0;
      valid_q   <= 1'b0;
      timeout_q <= 1'b0;
      hold_q    <= '0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      grant_q   <= grant_d;
      idx_q     <= idx_d;
      valid_q   <= valid_d;
      timeout_q <= timeout_d;
      hold_q    <= hold_d;
    end
  end

  // -------------------------------------------------------------------------
  // Outputs: straight from registers, no input-to-output paths.
  // -------------------------------------------------------------------------
  assign bus.grant     = grant_q;
  assign bus.gnt_idx   = idx_q;
  assign bus.gnt_valid = valid_q;
  assign bus.timeout   = timeout_q;

  assign dbg_state      = state_q;
  assign dbg_hold_cnt   = hold_q;
  assign dbg_hold_limit = (hold_q >= HOLD_LAST);

endmodule

// File: tb/tb_rr_arbiter4.sv
// ---------------------------------------------------------------------------
// tb_rr_arbiter4
// Directed bench for rr_arbiter4. Inputs change 1 ns after a rising edge and
// outputs are read at that same point, i.e. they show what the edge loaded.
// ---------------------------------------------------------------------------
module tb_rr_arbiter4;

  localparam int MAX_HOLD = 4;
  localparam int CNT_W    = 8;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_GRANT   = 2'd1;
  localparam logic [1:0] ST_RELEASE = 2'd2;

  logic             clk;
  logic             rst;
  logic [1:0]       dbg_state;
  logic [CNT_W-1:0] dbg_hold_cnt;
  logic             dbg_hold_limit;

  int tests_run    = 0;
  int tests_failed = 0;

  rr_arbiter4_if bus ();

  rr_arbiter4 #(
    .MAX_HOLD (MAX_HOLD),
    .CNT_W    (CNT_W)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .bus            (bus),
    .dbg_state      (dbg_state),
    .dbg_hold_cnt   (dbg_hold_cnt),
    .dbg_hold_limit (dbg_hold_limit)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    bus.req  = 4'b0000;
    bus.done = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // ---------------- invariants, checked every falling edge ----------------
  always @(negedge clk) begin
    if (!rst) begin
      logic [1:0] enc;
      enc = 2'd0;
      for (int i = 0; i < 4; i++) if (bus.grant[i]) enc = i[1:0];
      tests_run++;
      if ($countones(bus.grant) > 1 || (bus.gnt_valid !== (|bus.grant)) ||
          (bus.gnt_valid && bus.gnt_idx !== enc)) begin
        tests_failed++;
        $display("FAIL invariant: grant=%b gnt_idx=%0d gnt_valid=%b", bus.grant,
                 bus.gnt_idx, bus.gnt_valid);
      end
    end
  end

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst      = 1'b1;
    bus.req  = 4'b1111;
    bus.done = 1'b0;
    tick();
    tick();
    tests_run++;
    if (bus.grant !== 4'b0000 || bus.gnt_idx !== 2'd0 || bus.gnt_valid !== 1'b0 ||
        bus.timeout !== 1'b0 || dbg_state !== ST_IDLE) begin
      tests_failed++;
      $display("FAIL reset_outputs: grant=%b idx=%0d valid=%b timeout=%b state=%0d, want 0000/0/0/0/IDLE",
               bus.grant, bus.gnt_idx, bus.gnt_valid, bus.timeout, dbg_state);
    end
    rst     = 1'b0;
    bus.req = 4'b0000;
    tick();
  endtask

  task automatic test_basic();
    do_reset();
    bus.req = 4'b0001;
    tick();
    tests_run++;
    if (bus.grant !== 4'b0001 || bus.gnt_idx !== 2'd0 || bus.gnt_valid !== 1'b1 ||
        dbg_hold_cnt !== 8'd0) begin
      tests_failed++;
      $display("FAIL basic_grant: grant=%b idx=%0d valid=%b hold=%0d, want 0001/0/1/0",
               bus.grant, bus.gnt_idx, bus.gnt_valid, dbg_hold_cnt);
    end
    tick();
    tick();
    tests_run++;
    if (bus.grant !== 4'b0001 || dbg_hold_cnt !== 8'd2) begin
      tests_failed++;
      $display("FAIL basic_hold: grant=%b hold=%0d, want 0001/2", bus.grant, dbg_hold_cnt);
    end
    bus.done = 1'b1;
    tick();
    tests_run++;
    if (bus.grant !== 4'b0000 || bus.gnt_valid !== 1'b0 || bus.gnt_idx !== 2'd0 ||
        dbg_state !== ST_RELEASE) begin
      tests_failed++;
      $display("FAIL basic_release: grant=%b valid=%b idx=%0d state=%0d, want 0000/0/0/RELEASE",
               bus.grant, bus.gnt_valid, bus.gnt_idx, dbg_state);
    end
    bus.done = 1'b0;
    bus.req  = 4'b0000;
    tick();
    tests_run++;
    if (dbg_state !== ST_IDLE || bus.gnt_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL basic_idle: state=%0d valid=%b, want IDLE/0", dbg_state, bus.gnt_valid);
    end
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_g [5];
    exp_g[0] = 4'b0001;
    exp_g[1] = 4'b0010;
    exp_g[2] = 4'b0100;
    exp_g[3] = 4'b1000;
    exp_g[4] = 4'b0001;
    do_reset();
    bus.req = 4'b1111;
    for (int n = 0; n < 5; n++) begin
      tick();
      tests_run++;
      if (bus.grant !== exp_g[n] || bus.gnt_valid !== 1'b1) begin
        tests_failed++;
        $display("FAIL rr_order[%0d]: grant=%b valid=%b, want %b/1", n, bus.grant,
                 bus.gnt_valid, exp_g[n]);
      end
      bus.done = 1'b1;
      tick();
      bus.done = 1'b0;
      tests_run++;
      if (bus.grant !== 4'b0000 || bus.gnt_valid !== 1'b0) begin
        tests_failed++;
        $display("FAIL rr_gap[%0d]: grant=%b valid=%b, want 0000/0", n, bus.grant,
                 bus.gnt_valid);
      end
    end
    bus.req = 4'b0000;
    tick();
    tick();
  endtask

  task automatic test_wrap();
    do_reset();
    bus.req = 4'b0100;
    tick();
    tests_run++;
    if (bus.grant !== 4'b0100) begin
      tests_failed++;
      $display("FAIL wrap_setup: grant=%b, want 0100", bus.grant);
    end
    bus.req = 4'b0011;  // owner 2 drops, ptr becomes 2
    tick();
    tick();
    tests_run++;
    if (bus.grant !== 4'b0001 || bus.gnt_idx !== 2'd0) begin
      tests_failed++;
      $display("FAIL wrap_grant: grant=%b idx=%0d, want 0001/0", bus.grant, bus.gnt_idx);
    end
    bus.req = 4'b0010;
    tick();
    tick();
    tests_run++;
    if (bus.grant !== 4'b0010 || bus.gnt_idx !== 2'd1) begin
      tests_failed++;
      $display("FAIL wrap_next: grant=%b idx=%0d, want 0010/1", bus.grant, bus.gnt_idx);
    end
    bus.req = 4'b0000;
    tick();
    tick();
  endtask

  task automatic test_drop_and_combined();
    do_reset();
    bus.req = 4'b0010;
    tick();
    bus.req = 4'b1110;
    tick();
    tests_run++;
    if (bus.grant !== 4'b0010) begin
      tests_failed++;
      $display("FAIL no_preempt: grant=%b, want 0010", bus.grant);
    end
    bus.req = 4'b1100;  // owner 1 drops without done
    tick();
    tests_run++;
    if (bus.gnt_valid !== 1'b0 || bus.gnt_idx !== 2'd1 || dbg_state !== ST_RELEASE) begin
      tests_failed++;
      $display("FAIL drop_release: valid=%b idx=%0d state=%0d, want 0/1/RELEASE",
               bus.gnt_valid, bus.gnt_idx, dbg_state);
    end
    tick();
    tests_run++;
    if (bus.grant !== 4'b0100 || bus.gnt_idx !== 2'd2) begin
      tests_failed++;
      $display("FAIL drop_next: grant=%b idx=%0d, want 0100/2", bus.grant, bus.gnt_idx);
    end
    bus.done = 1'b1;
    bus.req  = 4'b1000;  // done and owner request fall together
    tick();
    bus.done = 1'b0;
    tests_run++;
    if (bus.gnt_valid !== 1'b0 || dbg_state !== ST_RELEASE) begin
      tests_failed++;
      $display("FAIL combined_release: valid=%b state=%0d, want 0/RELEASE",
               bus.gnt_valid, dbg_state);
    end
    tick();
    tests_run++;
    if (bus.grant !== 4'b1000 || bus.gnt_idx !== 2'd3) begin
      tests_failed++;
      $display("FAIL combined_next: grant=%b idx=%0d, want 1000/3", bus.grant, bus.gnt_idx);
    end
  endtask

  task automatic test_reset_mid_grant();
    // Entered with requester 3 owning the grant and req=1000.
    rst = 1'b1;
    tick();
    tests_run++;
    if (bus.grant !== 4'b0000 || bus.gnt_valid !== 1'b0 || bus.gnt_idx !== 2'd0 ||
        bus.timeout !== 1'b0 || dbg_state !== ST_IDLE) begin
      tests_failed++;
      $display("FAIL reset_mid: grant=%b valid=%b idx=%0d state=%0d, want 0000/0/0/IDLE",
               bus.grant, bus.gnt_valid, bus.gnt_idx, dbg_state);
    end
    rst = 1'b0;
    tick();
    tests_run++;
    if (bus.grant !== 4'b1000 || bus.gnt_idx !== 2'd3) begin
      tests_failed++;
      $display("FAIL reset_regrant: grant=%b idx=%0d, want 1000/3", bus.grant, bus.gnt_idx);
    end
    bus.req = 4'b0000;
    tick();
    tick();
  endtask

  task automatic test_done_ignored();
    do_reset();
    bus.done = 1'b1;
    tick();
    tick();
    tests_run++;
    if (dbg_state !== ST_IDLE || bus.gnt_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL done_idle: state=%0d valid=%b, want IDLE/0", dbg_state, bus.gnt_valid);
    end
    bus.done = 1'b0;
  endtask

  task automatic test_lone_rerequest();
    do_reset();
    bus.req = 4'b0001;
    tick();
    bus.done = 1'b1;
    tick();
    bus.done = 1'b0;
    tests_run++;
    if (dbg_state !== ST_RELEASE || bus.gnt_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL lone_release: state=%0d valid=%b, want RELEASE/0", dbg_state,
               bus.gnt_valid);
    end
    tick();
    tests_run++;
    if (bus.grant !== 4'b0001 || dbg_state !== ST_GRANT) begin
      tests_failed++;
      $display("FAIL lone_regrant: grant=%b state=%0d, want 0001/GRANT", bus.grant, dbg_state);
    end
    bus.req = 4'b0000;
    tick();
    tick();
  endtask

  task automatic test_timeout();
    do_reset();
    bus.req = 4'b0001;
    tick();
`ifdef RR_ARBITER4_TIMEOUT_EN
    for (int c = 0; c < MAX_HOLD; c++) begin
      tests_run++;
      if (bus.gnt_valid !== 1'b1 || bus.timeout !== 1'b0) begin
        tests_failed++;
        $display("FAIL timeout_hold[%0d]: valid=%b timeout=%b, want 1/0", c, bus.gnt_valid,
                 bus.timeout);
      end
      tick();
    end
    tests_run++;
    if (bus.gnt_valid !== 1'b0 || bus.timeout !== 1'b1 || dbg_state !== ST_RELEASE) begin
      tests_failed++;
      $display("FAIL timeout_pulse: valid=%b timeout=%b state=%0d, want 0/1/RELEASE",
               bus.gnt_valid, bus.timeout, dbg_state);
    end
    tick();
    tests_run++;
    if (bus.grant !== 4'b0001 || bus.timeout !== 1'b0) begin
      tests_failed++;
      $display("FAIL timeout_regrant: grant=%b timeout=%b, want 0001/0", bus.grant,
               bus.timeout);
    end
`else
    for (int c = 0; c < 22; c++) begin
      tests_run++;
      if (bus.grant !== 4'b0001 || bus.timeout !== 1'b0) begin
        tests_failed++;
        $display("FAIL no_timeout_hold[%0d]: grant=%b timeout=%b, want 0001/0", c, bus.grant,
                 bus.timeout);
      end
      tick();
    end
    tests_run++;
    if (dbg_hold_limit !== 1'b1) begin
      tests_failed++;
      $display("FAIL no_timeout_limit: hold_limit=%b, want 1", dbg_hold_limit);
    end
`endif
    bus.req = 4'b0000;
    tick();
    tick();
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    rst      = 1'b1;
    bus.req  = 4'b0000;
    bus.done = 1'b0;
    test_reset();
    test_basic();
    test_round_robin();
    test_wrap();
    test_drop_and_combined();
    test_reset_mid_grant();
    test_done_ignored();
    test_lone_rerequest();
    test_timeout();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
